imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream in, instruction-memory writes and core-hold status out.
// master drives the byte stream and restart; slave is the loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        restart;
    logic        we;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output rx_data, rx_valid, restart,
        input  we, waddr, wdata, cpu_hold, done, err
    );

    modport slave (
        input  rx_data, rx_valid, restart,
        output we, waddr, wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// UART boot loader: parses a length/payload/checksum frame into
// instruction-memory word writes and holds the core until it loads.
module imem_loader #(
    parameter int DEPTH_WORDS    = 16384,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic         clk,
    input logic         reset,
    imem_loader_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_SUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    bcnt_q;
    logic [23:0]   sh_q;
    logic [14:0]   n_q;
    logic [13:0]   idx_q;
    logic [7:0]    csum_q;
    logic [TW-1:0] tcnt_q;
    logic          we_q;
    logic [13:0]   waddr_q;
    logic [31:0]   wdata_q;

    logic          active;
    logic          take;
    logic          last_byte;
    logic          timer_on;
    logic          timeout;
    logic          hdr_bad;
    logic          last_word;
    logic          word_done;
    logic          rearm;
    logic          moved;
    logic [31:0]   group;

    // incoming byte lands on top; after 4 bytes byte 0 sits in [7:0]
    assign group     = {bus.rx_data, sh_q};
    assign active    = (state_q == S_HDR) || (state_q == S_DATA) ||
                       (state_q == S_SUM);
    assign take      = bus.rx_valid && active;
    assign last_byte = take && (bcnt_q == 2'd3);
    assign timer_on  = (state_q == S_DATA) || (state_q == S_SUM) ||
                       ((state_q == S_HDR) && (bcnt_q != 2'd0));
    assign timeout   = timer_on && !bus.rx_valid &&
                       (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign hdr_bad   = (group == 32'd0) || (group > 32'(DEPTH_WORDS));
    assign last_word = ({1'b0, idx_q} == (n_q - 15'd1));
    assign word_done = last_byte && (state_q == S_DATA);
    assign rearm     = bus.restart &&
                       ((state_q == S_DONE) || (state_q == S_ERR));
    assign moved     = (state_d != state_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_HDR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HDR: begin
                if (last_byte)    state_d = hdr_bad ? S_ERR : S_DATA;
                else if (timeout) state_d = S_ERR;
            end
            S_DATA: begin
                if (last_byte && last_word) state_d = S_SUM;
                else if (timeout)           state_d = S_ERR;
            end
            S_SUM: begin
                if (take)
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
                else if (timeout)
                    state_d = S_ERR;
            end
            S_DONE: if (bus.restart) state_d = S_HDR;
            S_ERR:  if (bus.restart) state_d = S_HDR;
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q  <= '0;
            sh_q    <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            tcnt_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= word_done;
            if (take) begin
                sh_q   <= group[31:8];
                bcnt_q <= bcnt_q + 2'd1;
            end
            if (moved)
                bcnt_q <= 2'd0;
            if (take && (state_q == S_DATA))
                csum_q <= csum_q ^ bus.rx_data;
            if (last_byte && (state_q == S_HDR)) begin
                n_q   <= group[14:0];
                idx_q <= '0;
            end
            if (word_done) begin
                waddr_q <= idx_q;
                wdata_q <= group;
                idx_q   <= idx_q + 14'd1;
            end
            if (!timer_on || bus.rx_valid || moved)
                tcnt_q <= '0;
            else
                tcnt_q <= tcnt_q + TW'(1);
            if (rearm) begin
                sh_q   <= '0;
                n_q    <= '0;
                idx_q  <= '0;
                csum_q <= '0;
                tcnt_q <= '0;
            end
        end
    end

    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.cpu_hold = (state_q != S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table, hand sequences, random frames
// against a frame-level reference model.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH_WORDS    (16384),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [13:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    bit          prev_we = 1'b0;
    int          dbl     = 0;

    always @(negedge clk) begin
        if (bus.we) begin
            wa_q.push_back(bus.waddr);
            wd_q.push_back(bus.wdata);
            wc_q.push_back(cyc);
        end
        if (bus.we && prev_we) dbl++;
        prev_we = bus.we;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.restart  = 1'b0;
        bus.rx_data  = 8'h00;
        idle(2);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        clear_mon();
    endtask

    task automatic chk_status(string tag, bit d, bit e);
        check({tag, ".done"}, bus.done, d);
        check({tag, ".err"}, bus.err, e);
        check({tag, ".hold"}, bus.cpu_hold, !d);
    endtask

    // frame under test, byte 0 first
    logic [7:0]  tx[$];
    logic [31:0] exp_w[$];
    bit          e_done, e_err;

    task automatic send_tx(int gapmax);
        foreach (tx[i]) begin
            send_byte(tx[i]);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
    endtask

    // Frame-level model: what a loader must produce for the byte list,
    // assuming the line then stays idle long enough to time out.
    task automatic model();
        longint n;
        logic [7:0] x;
        exp_w.delete();
        e_done = 1'b0;
        e_err  = 1'b0;
        if (tx.size() == 0) return;
        if (tx.size() < 4) begin e_err = 1'b1; return; end
        n = {tx[3], tx[2], tx[1], tx[0]};
        if (n == 0 || n > 16384) begin e_err = 1'b1; return; end
        for (int i = 0; i < n && (4 + 4 * i + 3) < tx.size(); i++)
            exp_w.push_back({tx[4+4*i+3], tx[4+4*i+2],
                             tx[4+4*i+1], tx[4+4*i]});
        if (tx.size() < 4 + 4 * n + 1) begin e_err = 1'b1; return; end
        x = 8'h00;
        for (int i = 4; i < 4 + 4 * n; i++) x ^= tx[i];
        if (tx[4 + 4 * n] == x) e_done = 1'b1;
        else                    e_err  = 1'b1;
    endtask

    task automatic chk_model(string tag);
        chk_status(tag, e_done, e_err);
        check({tag, ".nwr"}, wa_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wa_q.size(); i++) begin
            check($sformatf("%s.wa%0d", tag, i), wa_q[i], i);
            check($sformatf("%s.wd%0d", tag, i), wd_q[i], exp_w[i]);
        end
    endtask

    task automatic load_packed(int len, logic [127:0] f);
        tx.delete();
        for (int i = 0; i < len; i++)
            tx.push_back(f[8*(len-1-i) +: 8]);
    endtask

    typedef struct {
        int           len;
        logic [127:0] f;
        bit           done;
        bit           err;
        int           nwr;
        logic [31:0]  w0;
        logic [31:0]  w1;
    } vec_t;

    localparam logic [127:0] GOOD = 128'h02000000_13051000_93052000_b0;

    vec_t vt[9];

    initial begin
        int c;
        vt[0] = '{13, GOOD, 1'b1, 1'b0, 2, 32'h00100513, 32'h00200593};
        vt[1] = '{13, 128'h02000000_13051000_93052000_03,
                  1'b0, 1'b1, 2, 32'h00100513, 32'h00200593};
        vt[2] = '{13, 128'h02000000_13051000_93052000_04,
                  1'b0, 1'b1, 2, 32'h00100513, 32'h00200593};
        vt[3] = '{4, 128'h00000000, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vt[4] = '{4, 128'h01400000, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vt[5] = '{9, 128'h01000000_aabbccdd_00,
                  1'b1, 1'b0, 1, 32'hddccbbaa, 32'h0};
        vt[6] = '{8, 128'h00400000_01020304,
                  1'b0, 1'b1, 1, 32'h04030201, 32'h0};
        vt[7] = '{2, 128'h0102, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vt[8] = '{14, {GOOD[119:0], 8'hff},
                  1'b1, 1'b0, 2, 32'h00100513, 32'h00200593};

        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.restart  = 1'b0;
        bus.rx_data  = 8'h00;
        idle(2);
        check("rst.we", bus.we, 0);
        check("rst.waddr", bus.waddr, 0);
        check("rst.wdata", bus.wdata, 0);
        chk_status("rst", 1'b0, 1'b0);
        reset = 1'b0;
        idle(1);
        check("post_rst.we", bus.we, 0);

        // table vectors
        foreach (vt[v]) begin
            do_reset();
            load_packed(vt[v].len, vt[v].f);
            send_tx(0);
            idle(12);
            chk_status($sformatf("vec%0d", v), vt[v].done, vt[v].err);
            check($sformatf("vec%0d.nwr", v), wa_q.size(), vt[v].nwr);
            if (vt[v].nwr > 0 && wa_q.size() > 0) begin
                check($sformatf("vec%0d.wa0", v), wa_q[0], 0);
                check($sformatf("vec%0d.wd0", v), wd_q[0], vt[v].w0);
            end
            if (vt[v].nwr > 1 && wa_q.size() > 1) begin
                check($sformatf("vec%0d.wa1", v), wa_q[1], 1);
                check($sformatf("vec%0d.wd1", v), wd_q[1], vt[v].w1);
            end
        end

        // write lands exactly one cycle after the completing byte
        do_reset();
        load_packed(13, GOOD);
        for (int i = 0; i < 8; i++) send_byte(tx[i]);
        c = cyc;
        for (int i = 8; i < 13; i++) send_byte(tx[i]);
        idle(3);
        check("lat.n", wc_q.size(), 2);
        if (wc_q.size() > 0) check("lat.cyc", wc_q[0], c);
        chk_status("lat", 1'b1, 1'b0);

        // idle timeout mid-payload, then restart and reload
        do_reset();
        load_packed(7, 128'h04000000_aabbcc);
        send_tx(0);
        idle(7);
        check("to.early_err", bus.err, 0);
        idle(1);
        check("to.err", bus.err, 1);
        check("to.nwr", wa_q.size(), 0);
        pulse_restart();
        chk_status("to.rearm", 1'b0, 1'b0);
        load_packed(13, GOOD);
        send_tx(0);
        idle(3);
        model();
        chk_model("to.reload");

        // asynchronous reset mid-load, then a full reload
        do_reset();
        load_packed(13, GOOD);
        for (int i = 0; i < 9; i++) send_byte(tx[i]);
        check("ar.pre_wdata", bus.wdata, 32'h00100513);
        reset = 1'b1;
        #1;
        check("ar.wdata", bus.wdata, 0);
        check("ar.waddr", bus.waddr, 0);
        check("ar.we", bus.we, 0);
        chk_status("ar", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        send_tx(0);
        idle(3);
        model();
        chk_model("ar.reload");

        // restart with a byte in DONE: byte dropped, next 4 are header
        bus.restart  = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hff;
        @(negedge clk);
        bus.restart  = 1'b0;
        bus.rx_valid = 1'b0;
        clear_mon();
        chk_status("rsv", 1'b0, 1'b0);
        load_packed(9, 128'h01000000_11223344_44);
        send_tx(0);
        idle(3);
        chk_status("rsv.end", 1'b1, 1'b0);
        check("rsv.nwr", wa_q.size(), 1);
        if (wd_q.size() > 0) check("rsv.wd0", wd_q[0], 32'h44332211);

        // restart ignored mid-load; bytes ignored once DONE
        do_reset();
        load_packed(13, GOOD);
        for (int i = 0; i < 6; i++) send_byte(tx[i]);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        for (int i = 6; i < 13; i++) send_byte(tx[i]);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        idle(12);
        model();
        chk_model("ign");

        // random frames against the model
        for (int it = 0; it < 24; it++) begin
            int n;
            logic [7:0] x;
            if (it % 2 == 0) do_reset();
            else             pulse_restart();
            n = $urandom_range(1, 4);
            tx.delete();
            tx.push_back(8'(n));
            repeat (3) tx.push_back(8'h00);
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                x ^= b;
                tx.push_back(b);
            end
            if ($urandom_range(0, 1) == 1) tx.push_back(x);
            else tx.push_back(x ^ 8'($urandom_range(1, 255)));
            if ($urandom_range(0, 4) == 0)
                while (tx.size() > $urandom_range(1, 4 + 4 * n)) begin
                    void'(tx.pop_back());
                end
            send_tx(3);
            idle(12);
            model();
            chk_model($sformatf("rnd%0d", it));
        end

        check("we_gap", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
